// File: rtl/osd_pkg.sv
// ---------------------------------------------------------------------------
// osd_pkg
// Shared definitions for the OSD control/video packet decoder:
//   - state_t       : one-hot parser states (IDLE, CTRL, VIDEO, DROP)
//   - PKT_VIDEO     : Avalon-ST Video packet type of a video packet
//   - PKT_CTRL      : Avalon-ST Video packet type of a control packet
//   - CTRL_NIBBLES  : number of payload nibbles in a control packet
//   - ctrl_beats()  : payload beats needed to carry CTRL_NIBBLES at a plane count
// ---------------------------------------------------------------------------
package osd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_CTRL  = 4'b0010,
    ST_VIDEO = 4'b0100,
    ST_DROP  = 4'b1000
  } state_t;

  localparam logic [3:0] PKT_VIDEO    = 4'h0;
  localparam logic [3:0] PKT_CTRL     = 4'hF;
  localparam int         CTRL_NIBBLES = 9;

  // One nibble per plane per beat, so the payload length is a ceiling division.
  function automatic int ctrl_beats(input int planes);
    return (CTRL_NIBBLES + planes - 1) / planes;
  endfunction

endpackage

// File: rtl/osd_ctrl_decode_if.sv
// ---------------------------------------------------------------------------
// osd_ctrl_decode_if
// Avalon-ST streaming link (data/valid/SOP/EOP forward, ready backward).
//   master modport : drives data, valid, startofpacket, endofpacket; reads ready
//   slave  modport : reads data, valid, startofpacket, endofpacket; drives ready
// Parameter DATA_WIDTH sets the beat width.
// ---------------------------------------------------------------------------
interface osd_ctrl_decode_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  startofpacket;
  logic                  endofpacket;
  logic                  ready;

  modport master (
    output data, valid, startofpacket, endofpacket,
    input  ready
  );

  modport slave (
    input  data, valid, startofpacket, endofpacket,
    output ready
  );
endinterface

// File: rtl/osd_pixel_counter.sv
// ---------------------------------------------------------------------------
// osd_pixel_counter
// x/y coordinate counters for the pixel currently presented downstream.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_step     : a pixel was transferred this cycle
//   i_clear    : a video header was accepted; restart at 0/0 (wins over step)
//   i_width    : frame width used to wrap x
//   o_x, o_y   : coordinates of the current pixel
// A zero width has no wrap point, so x saturates instead of wrapping.
// ---------------------------------------------------------------------------
module osd_pixel_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_step,
  input  logic        i_clear,
  input  logic [15:0] i_width,
  output logic [15:0] o_x,
  output logic [15:0] o_y
);
  logic [15:0] r_x;
  logic [15:0] r_y;
  logic [15:0] w_x_last;

  assign w_x_last = i_width - 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_step) begin
      if (i_width == 16'd0) begin
        if (r_x != 16'hFFFF) r_x <= r_x + 16'd1;
      end else if (r_x == w_x_last) begin
        r_x <= '0;
        r_y <= r_y + 16'd1;
      end else begin
        r_x <= r_x + 16'd1;
      end
    end
  end

  assign o_x = r_x;
  assign o_y = r_y;
endmodule

// File: rtl/osd_ctrl_decode.sv
// ---------------------------------------------------------------------------
// osd_ctrl_decode
// Avalon-ST Video packet parser in front of the OSD generator. Latches
// width/height/interlace from control packets, drops user packets, strips all
// headers and passes video pixels through with zero latency plus x/y coords.
//   clk, rst_n         : clock, asynchronous active-low reset
//   din   (slave)      : input packet stream
//   dout  (master)     : video pixel stream (SOP = first pixel, EOP = last)
//   video_width/height : latched frame size (16b each)
//   video_interlaced   : latched interlace nibble
//   ctrl_update        : 1-cycle pulse after new control values are latched
//   pixel_x, pixel_y   : coordinates of the current dout beat
//   frame_error        : only with OSD_FRAME_CHECK_EN defined; pulses after a
//                        video EOP at the wrong coordinates or an abandoned frame
// Optional feature macro: OSD_FRAME_CHECK_EN.
// ---------------------------------------------------------------------------
module osd_ctrl_decode
  import osd_pkg::*;
#(
  parameter int DATA_WIDTH  = 24,
  parameter int DATA_BITS   = 8,
  parameter int DATA_PLANES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  osd_ctrl_decode_if.slave   din,
  osd_ctrl_decode_if.master  dout,
  output logic [15:0]        video_width,
  output logic [15:0]        video_height,
  output logic [3:0]         video_interlaced,
  output logic               ctrl_update,
  output logic [15:0]        pixel_x,
  output logic [15:0]        pixel_y
`ifdef OSD_FRAME_CHECK_EN
  ,
  output logic               frame_error
`endif
);
  localparam int CTRL_BEATS = ctrl_beats(DATA_PLANES);
  localparam int SHADOW_W   = 4 * CTRL_NIBBLES;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_run;          // low only while in reset; gates din.ready
  logic                  r_first;        // next pixel is the first of the frame
  logic                  r_ctrl_update;
  logic [3:0]            r_beat_cnt;     // control payload beats seen so far
  logic [SHADOW_W-1:0]   r_shadow;       // {width, height, interlaced}
  logic [SHADOW_W-1:0]   w_shadow_next;
  logic [15:0]           r_width;
  logic [15:0]           r_height;
  logic [3:0]            r_interlaced;
  logic [DATA_WIDTH-1:0] w_pix_data;
  logic [3:0]            w_type;
  logic                  w_din_ready;
  logic                  w_xfer;
  logic                  w_sop_xfer;
  logic                  w_hdr_video;
  logic                  w_pix_valid;
  logic                  w_pix_xfer;
  logic                  w_ctrl_beat;
  logic                  w_ctrl_done;
  logic                  w_commit;

  // In VIDEO the input is throttled directly by the downstream sink.
  assign w_din_ready = (r_state == ST_VIDEO) ? dout.ready : r_run;
  assign din.ready   = w_din_ready;

  assign w_xfer      = din.valid & w_din_ready;
  assign w_sop_xfer  = w_xfer & din.startofpacket;
  assign w_type      = din.data[3:0];
  assign w_hdr_video = w_sop_xfer & (w_type == PKT_VIDEO);
  // An SOP seen in VIDEO is a new header, never a pixel.
  assign w_pix_valid = (r_state == ST_VIDEO) & din.valid & ~din.startofpacket;
  assign w_pix_xfer  = w_pix_valid & dout.ready;
  assign w_pix_data  = din.data;

  assign w_ctrl_beat = (r_state == ST_CTRL) & w_xfer & ~din.startofpacket;
  assign w_ctrl_done = ({1'b0, r_beat_cnt} + 5'd1) >= 5'(CTRL_BEATS);
  assign w_commit    = w_ctrl_beat & din.endofpacket & w_ctrl_done;

  // Nibble gi arrives in payload beat gi/PLANES on plane gi%PLANES; the merged
  // view lets the EOP beat's own nibbles be committed at the same edge.
  genvar gi;
  generate
    for (gi = 0; gi < CTRL_NIBBLES; gi++) begin : g_nibble
      localparam int BEAT = gi / DATA_PLANES;
      localparam int LSB  = (gi % DATA_PLANES) * DATA_BITS;
      localparam int POS  = (CTRL_NIBBLES - 1 - gi) * 4;
      assign w_shadow_next[POS +: 4] =
        (w_ctrl_beat && (r_beat_cnt == 4'(BEAT))) ? din.data[LSB +: 4]
                                                  : r_shadow[POS +: 4];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next       = r_state;
    dout.data          = '0;
    dout.valid         = 1'b0;
    dout.startofpacket = 1'b0;
    dout.endofpacket   = 1'b0;
    case (r_state)
      ST_CTRL, ST_DROP: begin
        if (w_xfer && din.endofpacket) w_state_next = ST_IDLE;
      end
      ST_VIDEO: begin
        dout.data          = w_pix_data;
        dout.valid         = w_pix_valid;
        dout.startofpacket = w_pix_valid & r_first;
        dout.endofpacket   = w_pix_valid & din.endofpacket;
        if (w_pix_xfer && din.endofpacket) w_state_next = ST_IDLE;
      end
      default: ;
    endcase
    // Any accepted SOP restarts parsing, abandoning whatever was in flight.
    if (w_sop_xfer) begin
      if (din.endofpacket)          w_state_next = ST_IDLE;
      else if (w_type == PKT_CTRL)  w_state_next = ST_CTRL;
      else if (w_type == PKT_VIDEO) w_state_next = ST_VIDEO;
      else                          w_state_next = ST_DROP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run         <= 1'b0;
      r_first       <= 1'b0;
      r_ctrl_update <= 1'b0;
      r_beat_cnt    <= '0;
      r_shadow      <= '0;
      r_width       <= '0;
      r_height      <= '0;
      r_interlaced  <= '0;
    end else begin
      r_run         <= 1'b1;
      r_ctrl_update <= w_commit;
      if (w_hdr_video)     r_first <= 1'b1;
      else if (w_pix_xfer) r_first <= 1'b0;
      if (w_sop_xfer) begin
        r_beat_cnt <= '0;
      end else if (w_ctrl_beat && (r_beat_cnt < 4'(CTRL_BEATS))) begin
        r_beat_cnt <= r_beat_cnt + 4'd1;
        r_shadow   <= w_shadow_next;
      end
      if (w_commit) {r_width, r_height, r_interlaced} <= w_shadow_next;
    end
  end

  osd_pixel_counter u_pixel_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_step  (w_pix_xfer),
    .i_clear (w_hdr_video),
    .i_width (r_width),
    .o_x     (pixel_x),
    .o_y     (pixel_y)
  );

`ifdef OSD_FRAME_CHECK_EN
  logic        r_frame_error;
  logic [15:0] w_x_last;
  logic [15:0] w_y_last;

  assign w_x_last = r_width - 16'd1;
  assign w_y_last = r_height - 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_error <= 1'b0;
    end else begin
      r_frame_error <= (w_pix_xfer & din.endofpacket &
                        ((pixel_x != w_x_last) | (pixel_y != w_y_last))) |
                       ((r_state == ST_VIDEO) & w_sop_xfer);
    end
  end

  assign frame_error = r_frame_error;
`endif

  assign video_width      = r_width;
  assign video_height     = r_height;
  assign video_interlaced = r_interlaced;
  assign ctrl_update      = r_ctrl_update;
endmodule

// File: tb/tb_osd_ctrl_decode.sv
// ---------------------------------------------------------------------------
// tb_osd_ctrl_decode
// Directed bench for osd_ctrl_decode (3 planes of 8 bits): control parsing,
// video pass-through with coordinates, backpressure, early control EOP,
// user-packet dropping and reset in the middle of a frame.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_osd_ctrl_decode;
  int checks = 0;
  int errors = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] video_width, video_height, pixel_x, pixel_y;
  logic [3:0]  video_interlaced;
  logic        ctrl_update;
`ifdef OSD_FRAME_CHECK_EN
  logic        frame_error;
`endif

  always #5 clk = ~clk;

  osd_ctrl_decode_if #(.DATA_WIDTH(24)) din_if ();
  osd_ctrl_decode_if #(.DATA_WIDTH(24)) dout_if ();

  osd_ctrl_decode #(.DATA_WIDTH(24), .DATA_BITS(8), .DATA_PLANES(3)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .din              (din_if),
    .dout             (dout_if),
    .video_width      (video_width),
    .video_height     (video_height),
    .video_interlaced (video_interlaced),
    .ctrl_update      (ctrl_update),
    .pixel_x          (pixel_x),
    .pixel_y          (pixel_y)
`ifdef OSD_FRAME_CHECK_EN
    ,
    .frame_error      (frame_error)
`endif
  );

  // Record of every downstream pixel transfer, sampled mid-cycle.
  typedef struct {
    logic [23:0] d;
    logic        sop;
    logic        eop;
    logic [15:0] x;
    logic [15:0] y;
  } pix_t;
  pix_t pq[$];
  int   upd_cnt = 0;
  int   dv_cnt  = 0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (dout_if.valid === 1'b1 && dout_if.ready === 1'b1)
        pq.push_back('{dout_if.data, dout_if.startofpacket, dout_if.endofpacket, pixel_x, pixel_y});
      if (ctrl_update === 1'b1) upd_cnt++;
      if (dout_if.valid === 1'b1) dv_cnt++;
    end
  end

  // Present one beat and hold it until accepted; returns #1 after the transfer edge.
  task automatic send(input logic [23:0] d, input logic s, input logic e);
    bit done;
    done = 0;
    din_if.data = d;
    din_if.valid = 1'b1;
    din_if.startofpacket = s;
    din_if.endofpacket = e;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (din_if.ready === 1'b1) done = 1;
      @(posedge clk);
      #1;
    end
    din_if.valid = 1'b0;
    din_if.startofpacket = 1'b0;
    din_if.endofpacket = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat %h not accepted within 100 cycles", d);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    din_if.valid = 1'b1;
    din_if.data = 24'h000000;
    din_if.startofpacket = 1'b1;
    din_if.endofpacket = 1'b0;
    dout_if.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (din_if.ready !== 1'b0) begin errors++; $display("FAIL reset_din_ready: got %b want 0", din_if.ready); end
    checks++; if (dout_if.valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %b want 0", dout_if.valid); end
    checks++; if ({video_width, video_height, video_interlaced} !== 36'h0) begin errors++; $display("FAIL reset_ctrl_regs: got %h want 0", {video_width, video_height, video_interlaced}); end
    checks++; if ({pixel_x, pixel_y, ctrl_update} !== 33'h0) begin errors++; $display("FAIL reset_counters: got %h want 0", {pixel_x, pixel_y, ctrl_update}); end
    din_if.valid = 1'b0;
    din_if.startofpacket = 1'b0;
    rst_n = 1'b1;
    idle(1);
    checks++; if (din_if.ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", din_if.ready); end
    $display("test_reset done");
  endtask

  // w=0x0050 h=0x0020 il=0; upper nibble of every plane byte is noise.
  task automatic test_ctrl_parse;
    upd_cnt = 0;
    dv_cnt = 0;
    send(24'h00000F, 1'b1, 1'b0);
    send(24'h35A0B0, 1'b0, 1'b0);
    send(24'hC0D0E0, 1'b0, 1'b0);
    checks++; if (video_width !== 16'd0) begin errors++; $display("FAIL ctrl_no_early_commit: width %0d want 0", video_width); end
    send(24'h707092, 1'b0, 1'b1);
    checks++; if (ctrl_update !== 1'b1) begin errors++; $display("FAIL ctrl_update_pulse: got %b want 1", ctrl_update); end
    checks++; if (video_width !== 16'd80) begin errors++; $display("FAIL ctrl_width: got %0d want 80", video_width); end
    checks++; if (video_height !== 16'd32) begin errors++; $display("FAIL ctrl_height: got %0d want 32", video_height); end
    checks++; if (video_interlaced !== 4'h0) begin errors++; $display("FAIL ctrl_il: got %h want 0", video_interlaced); end
    idle(3);
    checks++; if (upd_cnt !== 1) begin errors++; $display("FAIL ctrl_update_count: got %0d want 1", upd_cnt); end
    checks++; if (dv_cnt !== 0) begin errors++; $display("FAIL ctrl_no_dout: got %0d valid cycles want 0", dv_cnt); end
    $display("test_ctrl_parse done width=%0d height=%0d", video_width, video_height);
  endtask

  // w=4 h=2 il=0xA, then an 8-pixel frame.
  task automatic test_video_frame;
    send(24'h00000F, 1'b1, 1'b0);
    send(24'h000000, 1'b0, 1'b0);
    send(24'h000004, 1'b0, 1'b0);
    send(24'h0A0200, 1'b0, 1'b1);
    idle(1);
    checks++; if ({video_width, video_height, video_interlaced} !== {16'd4, 16'd2, 4'hA}) begin errors++; $display("FAIL ctrl2_values: got %h want %h", {video_width, video_height, video_interlaced}, {16'd4, 16'd2, 4'hA}); end
    pq.delete();
    send(24'h000000, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) send(24'h100000 + 24'(i * 3), 1'b0, i == 7);
    idle(1);
    checks++; if (pq.size() !== 8) begin errors++; $display("FAIL video_count: got %0d want 8", pq.size()); end
    for (int i = 0; i < 8 && i < pq.size(); i++) begin
      checks++;
      if (pq[i].d !== 24'h100000 + 24'(i * 3) || pq[i].sop !== (i == 0) || pq[i].eop !== (i == 7) ||
          pq[i].x !== 16'(i % 4) || pq[i].y !== 16'(i / 4)) begin
        errors++;
        $display("FAIL video_pixel%0d: got d=%h sop=%b eop=%b x=%0d y=%0d want d=%h sop=%b eop=%b x=%0d y=%0d",
                 i, pq[i].d, pq[i].sop, pq[i].eop, pq[i].x, pq[i].y,
                 24'h100000 + 24'(i * 3), i == 0, i == 7, i % 4, i / 4);
      end
    end
    checks++; if (din_if.ready !== 1'b1 || dout_if.valid !== 1'b0) begin errors++; $display("FAIL video_back_idle: ready=%b valid=%b want 1/0", din_if.ready, dout_if.valid); end
    $display("test_video_frame done pixels=%0d", pq.size());
  endtask

  task automatic test_backpressure;
    int idx;
    int cyc;
    bit acc;
    int bad;
    pq.delete();
    send(24'h000000, 1'b1, 1'b0);
    idx = 0;
    cyc = 0;
    bad = 0;
    dout_if.ready = 1'b0;
    while (idx < 8 && cyc < 100) begin
      din_if.data = 24'h200000 + 24'(idx);
      din_if.valid = 1'b1;
      din_if.endofpacket = (idx == 7);
      @(negedge clk);
      if (din_if.ready !== dout_if.ready) bad++;
      acc = (din_if.ready === 1'b1);
      @(posedge clk);
      #1;
      if (acc) idx++;
      dout_if.ready = ~dout_if.ready;
      cyc++;
    end
    din_if.valid = 1'b0;
    din_if.endofpacket = 1'b0;
    dout_if.ready = 1'b1;
    idle(1);
    checks++; if (bad !== 0 || idx !== 8) begin errors++; $display("FAIL bp_ready_mirror: mismatched cycles %0d sent %0d want 0/8", bad, idx); end
    checks++; if (pq.size() !== 8) begin errors++; $display("FAIL bp_count: got %0d want 8", pq.size()); end
    for (int i = 0; i < 8 && i < pq.size(); i++) begin
      checks++;
      if (pq[i].d !== 24'h200000 + 24'(i) || pq[i].x !== 16'(i % 4) || pq[i].y !== 16'(i / 4)) begin
        errors++;
        $display("FAIL bp_pixel%0d: got d=%h x=%0d y=%0d want d=%h x=%0d y=%0d",
                 i, pq[i].d, pq[i].x, pq[i].y, 24'h200000 + 24'(i), i % 4, i / 4);
      end
    end
    $display("test_backpressure done cycles=%0d", cyc);
  endtask

  task automatic test_ctrl_early_eop;
    upd_cnt = 0;
    send(24'h00000F, 1'b1, 1'b0);
    send(24'h090909, 1'b0, 1'b0);
    send(24'h090909, 1'b0, 1'b1);
    idle(3);
    checks++; if (upd_cnt !== 0) begin errors++; $display("FAIL early_eop_update: got %0d pulses want 0", upd_cnt); end
    checks++; if ({video_width, video_height, video_interlaced} !== {16'd4, 16'd2, 4'hA}) begin errors++; $display("FAIL early_eop_hold: got %h want %h", {video_width, video_height, video_interlaced}, {16'd4, 16'd2, 4'hA}); end
    $display("test_ctrl_early_eop done");
  endtask

  task automatic test_user_drop;
    pq.delete();
    dv_cnt = 0;
    send(24'h000003, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) send(24'h30000F + 24'(i << 8), 1'b0, i == 9);
    idle(1);
    checks++; if (dv_cnt !== 0) begin errors++; $display("FAIL user_dropped: got %0d valid cycles want 0", dv_cnt); end
    send(24'h000000, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) send(24'h500000 + 24'(i), 1'b0, i == 7);
    idle(1);
    checks++; if (pq.size() !== 8 || dv_cnt !== 8) begin errors++; $display("FAIL user_then_video_count: got %0d/%0d want 8/8", pq.size(), dv_cnt); end
    if (pq.size() == 8) begin
      checks++; if (pq[0].d !== 24'h500000 || pq[0].sop !== 1'b1) begin errors++; $display("FAIL user_then_video_first: got d=%h sop=%b want 500000/1", pq[0].d, pq[0].sop); end
      checks++; if (pq[7].eop !== 1'b1 || pq[7].x !== 16'd3 || pq[7].y !== 16'd1) begin errors++; $display("FAIL user_then_video_last: got eop=%b x=%0d y=%0d want 1/3/1", pq[7].eop, pq[7].x, pq[7].y); end
    end
    $display("test_user_drop done");
  endtask

  task automatic test_reset_mid_video;
    send(24'h000000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send(24'h600000 + 24'(i), 1'b0, 1'b0);
    din_if.data = 24'h6000AA;
    din_if.valid = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++; if (din_if.ready !== 1'b0 || dout_if.valid !== 1'b0) begin errors++; $display("FAIL midreset_hs: ready=%b valid=%b want 0/0", din_if.ready, dout_if.valid); end
    checks++; if ({video_width, video_height, video_interlaced, pixel_x, pixel_y} !== 68'h0) begin errors++; $display("FAIL midreset_regs: got %h want 0", {video_width, video_height, video_interlaced, pixel_x, pixel_y}); end
    @(posedge clk);
    #1;
    din_if.valid = 1'b0;
    rst_n = 1'b1;
    idle(1);
    pq.delete();
    send(24'h000000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send(24'h700000 + 24'(i), 1'b0, i == 2);
    idle(1);
    checks++; if (pq.size() !== 3) begin errors++; $display("FAIL postreset_count: got %0d want 3", pq.size()); end
    for (int i = 0; i < 3 && i < pq.size(); i++) begin
      checks++;
      if (pq[i].d !== 24'h700000 + 24'(i) || pq[i].sop !== (i == 0) || pq[i].eop !== (i == 2) ||
          pq[i].x !== 16'(i) || pq[i].y !== 16'd0) begin
        errors++;
        $display("FAIL postreset_pixel%0d: got d=%h sop=%b eop=%b x=%0d y=%0d want d=%h sop=%b eop=%b x=%0d y=0",
                 i, pq[i].d, pq[i].sop, pq[i].eop, pq[i].x, pq[i].y, 24'h700000 + 24'(i), i == 0, i == 2, i);
      end
    end
    $display("test_reset_mid_video done");
  endtask

  initial begin
    din_if.data = '0;
    din_if.valid = 1'b0;
    din_if.startofpacket = 1'b0;
    din_if.endofpacket = 1'b0;
    dout_if.ready = 1'b1;
    test_reset();
    test_ctrl_parse();
    test_video_frame();
    test_backpressure();
    test_ctrl_early_eop();
    test_user_drop();
    test_reset_mid_video();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
